// File: rtl/v_v2k_pipe.sv
// v_v2k_pipe: DEPTH-stage valid/ready register pipeline carrying WIDTH+1-bit
// data, with a combinational ready chain, synchronous flush and an occupancy
// counter.
// Optional build macro: V_V2K_PIPE_PARITY_EN adds per-stage even-parity
// storage and a registered parity_err output.
module v_v2k_pipe #(
   parameter int WIDTH = 16,
   parameter int DEPTH = 4,
   parameter int CNT_W = 5
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [WIDTH:0]   in_data,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [WIDTH:0]   out_data,
   input  logic             flush,
   output logic [CNT_W-1:0] occupancy
`ifdef V_V2K_PIPE_PARITY_EN
   ,
   output logic             parity_err
`endif
);

   localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

   logic [DEPTH-1:0] v_q, v_d;
   logic [DEPTH-1:0] en;
   logic [DEPTH-1:0] v_in;
   logic [DEPTH-1:0] ld;
   logic [WIDTH:0]   d_q  [DEPTH];
   logic [WIDTH:0]   d_d  [DEPTH];
   logic [WIDTH:0]   d_in [DEPTH];
   logic [CNT_W-1:0] occ_q, occ_d;
   logic             accept;
   logic             emit;

   // Each stage takes its valid/data from the stage before (stage 0 from the producer).
   for (genvar g = 0; g < DEPTH; g++) begin : g_stage
      if (g == 0) begin : g_first
         assign v_in[g] = in_valid;
         assign d_in[g] = in_data;
      end else begin : g_rest
         assign v_in[g] = v_q[g-1];
         assign d_in[g] = d_q[g-1];
      end
   end

   // Ready chain: a stage may advance if empty or if the stage after it advances.
   always_comb begin
      en = '0;
      en[DEPTH-1] = ~v_q[DEPTH-1] | out_ready;
      for (int i = DEPTH - 2; i >= 0; i--) begin
         en[i] = ~v_q[i] | en[i+1];
      end
   end

   assign in_ready  = en[0] & ~flush;
   assign accept    = in_valid & in_ready;
   assign emit      = v_q[DEPTH-1] & out_ready;
   assign out_valid = v_q[DEPTH-1];
   assign out_data  = d_q[DEPTH-1];
   assign occupancy = occ_q;

   // Next-state for stage valid/data and the occupancy counter; flush clears valids only.
   always_comb begin
      v_d   = v_q;
      occ_d = occ_q;
      for (int i = 0; i < DEPTH; i++) begin
         d_d[i] = d_q[i];
         ld[i]  = en[i] & v_in[i] & ~flush;
         if (ld[i]) begin
            d_d[i] = d_in[i];
         end else begin
            d_d[i] = d_q[i];
         end
         if (flush) begin
            v_d[i] = 1'b0;
         end else if (en[i]) begin
            v_d[i] = v_in[i];
         end else begin
            v_d[i] = v_q[i];
         end
      end
      if (flush) begin
         occ_d = '0;
      end else begin
         case ({accept, emit})
            2'b10:   occ_d = occ_q + CNT_ONE;
            2'b01:   occ_d = occ_q - CNT_ONE;
            default: occ_d = occ_q;
         endcase
      end
   end

   // Stage and counter registers with synchronous reset.
   always_ff @(posedge clk) begin
      if (rst) begin
         v_q   <= '0;
         occ_q <= '0;
         for (int i = 0; i < DEPTH; i++) begin
            d_q[i] <= '0;
         end
      end else begin
         v_q   <= v_d;
         occ_q <= occ_d;
         for (int i = 0; i < DEPTH; i++) begin
            d_q[i] <= d_d[i];
         end
      end
   end

`ifdef V_V2K_PIPE_PARITY_EN
   logic [DEPTH-1:0] par_q, par_d;
   logic             perr_q, perr_d;

   function automatic logic even_par(input logic [WIDTH:0] x);
      return ^x;
   endfunction

   // Parity bits travel with the data; error flags a mismatch at the output stage.
   always_comb begin
      par_d = par_q;
      for (int i = 0; i < DEPTH; i++) begin
         if (ld[i]) begin
            par_d[i] = even_par(d_in[i]);
         end else begin
            par_d[i] = par_q[i];
         end
      end
      perr_d = v_q[DEPTH-1] & (par_q[DEPTH-1] != even_par(d_q[DEPTH-1]));
   end

   // Parity storage and the registered error flag.
   always_ff @(posedge clk) begin
      if (rst) begin
         par_q  <= '0;
         perr_q <= 1'b0;
      end else begin
         par_q  <= par_d;
         perr_q <= perr_d;
      end
   end

   assign parity_err = perr_q;
`endif

endmodule

// File: tb/tb_v_v2k_pipe.sv
// Directed bench for v_v2k_pipe: a DEPTH=4/WIDTH=16 instance exercised with
// hand-computed vectors, and a DEPTH=1/WIDTH=7 instance with random handshakes.
// Both instances are tracked by in-order scoreboards.
module tb_v_v2k_pipe;

   logic clk = 1'b0;
   logic rst;
   always #5 clk = ~clk;

   int checks = 0;
   int errors = 0;

   // Instance A: DEPTH=4, WIDTH=16
   logic        a_in_valid, a_in_ready, a_out_valid, a_out_ready, a_flush;
   logic [16:0] a_in_data, a_out_data;
   logic [4:0]  a_occ;
   logic        a_perr;

   // Instance B: DEPTH=1, WIDTH=7
   logic        b_in_valid, b_in_ready, b_out_valid, b_out_ready, b_flush;
   logic [7:0]  b_in_data, b_out_data;
   logic [4:0]  b_occ;
   logic        b_perr;

   logic [16:0] qa[$];
   logic [7:0]  qb[$];

   v_v2k_pipe #(.WIDTH(16), .DEPTH(4), .CNT_W(5)) u_a (
      .clk(clk), .rst(rst),
      .in_valid(a_in_valid), .in_ready(a_in_ready), .in_data(a_in_data),
      .out_valid(a_out_valid), .out_ready(a_out_ready), .out_data(a_out_data),
      .flush(a_flush), .occupancy(a_occ)
`ifdef V_V2K_PIPE_PARITY_EN
      , .parity_err(a_perr)
`endif
   );

   v_v2k_pipe #(.WIDTH(7), .DEPTH(1), .CNT_W(5)) u_b (
      .clk(clk), .rst(rst),
      .in_valid(b_in_valid), .in_ready(b_in_ready), .in_data(b_in_data),
      .out_valid(b_out_valid), .out_ready(b_out_ready), .out_data(b_out_data),
      .flush(b_flush), .occupancy(b_occ)
`ifdef V_V2K_PIPE_PARITY_EN
      , .parity_err(b_perr)
`endif
   );

`ifndef V_V2K_PIPE_PARITY_EN
   assign a_perr = 1'b0;
   assign b_perr = 1'b0;
`endif

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // Scoreboard A: compare each emitted beat with the oldest accepted one.
   always @(posedge clk) begin
      if (rst) begin
         qa.delete();
      end else begin
         if (a_out_valid && a_out_ready) begin
            check("a_sb_nonempty", {31'd0, qa.size() != 0}, 32'd1);
            if (qa.size() != 0) check("a_sb_data", {15'd0, a_out_data}, {15'd0, qa.pop_front()});
         end
         if (a_flush) qa.delete();
         else if (a_in_valid && a_in_ready) qa.push_back(a_in_data);
`ifdef V_V2K_PIPE_PARITY_EN
         check("a_parity_err", {31'd0, a_perr}, 32'd0);
`endif
      end
   end

   // Scoreboard B: same in-order check for the single-stage instance.
   always @(posedge clk) begin
      if (rst) begin
         qb.delete();
      end else begin
         if (b_out_valid && b_out_ready) begin
            check("b_sb_nonempty", {31'd0, qb.size() != 0}, 32'd1);
            if (qb.size() != 0) check("b_sb_data", {24'd0, b_out_data}, {24'd0, qb.pop_front()});
         end
         if (b_flush) qb.delete();
         else if (b_in_valid && b_in_ready) qb.push_back(b_in_data);
`ifdef V_V2K_PIPE_PARITY_EN
         check("b_parity_err", {31'd0, b_perr}, 32'd0);
`endif
      end
   end

   initial begin
      rst = 1'b1;
      a_in_valid = 1'b0; a_in_data = 17'h0; a_out_ready = 1'b0; a_flush = 1'b0;
      b_in_valid = 1'b0; b_in_data = 8'h0;  b_out_ready = 1'b0; b_flush = 1'b0;

      // Reset then idle
      tick();
      check("rst_in_ready", {31'd0, a_in_ready}, 32'd1);
      tick();
      rst = 1'b0;
      tick();
      check("idle_out_valid", {31'd0, a_out_valid}, 32'd0);
      check("idle_occ", {27'd0, a_occ}, 32'd0);
      check("idle_in_ready", {31'd0, a_in_ready}, 32'd1);
      check("idle_out_data", {15'd0, a_out_data}, 32'h0);

      // Stream 8 beats with the consumer always ready
      a_out_ready = 1'b1;
      for (int c = 1; c <= 12; c++) begin
         a_in_valid = (c <= 8);
         a_in_data  = 17'(c);
         tick();
         if (c <= 3) check("stream_latency", {31'd0, a_out_valid}, 32'd0);
         if (c >= 4 && c <= 11) begin
            check("stream_valid", {31'd0, a_out_valid}, 32'd1);
            check("stream_data", {15'd0, a_out_data}, 32'(c - 3));
         end
         if (c >= 4 && c <= 8) check("stream_occ", {27'd0, a_occ}, 32'd4);
         if (c == 12) begin
            check("stream_end_valid", {31'd0, a_out_valid}, 32'd0);
            check("stream_end_occ", {27'd0, a_occ}, 32'd0);
         end
      end

      // Fill with the consumer stalled; the fifth beat must be refused
      a_out_ready = 1'b0;
      for (int k = 0; k < 5; k++) begin
         a_in_valid = 1'b1;
         a_in_data  = 17'h0A0 + 17'(k);
         #1;
         check("fill_in_ready", {31'd0, a_in_ready}, (k < 4) ? 32'd1 : 32'd0);
         tick();
         check("fill_occ", {27'd0, a_occ}, (k < 4) ? 32'(k + 1) : 32'd4);
      end
      check("full_hold_data", {15'd0, a_out_data}, 32'h0A0);
      a_in_valid = 1'b0;
      a_out_ready = 1'b1;
      for (int j = 1; j <= 4; j++) begin
         tick();
         if (j < 4) check("drain_data", {15'd0, a_out_data}, 32'h0A0 + 32'(j));
      end
      check("drain_empty_valid", {31'd0, a_out_valid}, 32'd0);
      check("drain_empty_occ", {27'd0, a_occ}, 32'd0);
      check("empty_hold_data", {15'd0, a_out_data}, 32'h0A3);

      // Full with simultaneous accept and emit
      a_out_ready = 1'b0;
      for (int k = 0; k < 4; k++) begin
         a_in_valid = 1'b1;
         a_in_data  = 17'h0B0 + 17'(k);
         tick();
      end
      check("full_occ", {27'd0, a_occ}, 32'd4);
      a_out_ready = 1'b1;
      for (int k = 4; k < 14; k++) begin
         a_in_data = 17'h0B0 + 17'(k);
         tick();
         check("full_pass_occ", {27'd0, a_occ}, 32'd4);
      end
      a_in_valid = 1'b0;
      for (int n = 0; n < 20 && a_occ != 5'd0; n++) tick();
      check("full_drain_occ", {27'd0, a_occ}, 32'd0);
      check("full_sb_empty", 32'(qa.size()), 32'd0);

      // Flush with three beats in flight and a beat offered in the same cycle
      a_out_ready = 1'b0;
      for (int k = 0; k < 3; k++) begin
         a_in_valid = 1'b1;
         a_in_data  = 17'h0C0 + 17'(k);
         tick();
      end
      check("pre_flush_occ", {27'd0, a_occ}, 32'd3);
      a_flush = 1'b1;
      a_in_data = 17'h0CF;
      #1;
      check("flush_in_ready", {31'd0, a_in_ready}, 32'd0);
      tick();
      a_flush = 1'b0;
      a_in_valid = 1'b0;
      check("flush_occ", {27'd0, a_occ}, 32'd0);
      check("flush_out_valid", {31'd0, a_out_valid}, 32'd0);
      a_out_ready = 1'b1;
      for (int n = 0; n < 6; n++) begin
         tick();
         check("post_flush_valid", {31'd0, a_out_valid}, 32'd0);
      end

      // Single-stage instance with random handshakes
      for (int n = 0; n < 200; n++) begin
         b_in_valid  = 1'($urandom_range(0, 1));
         b_out_ready = 1'($urandom_range(0, 1));
         b_in_data   = 8'($urandom_range(0, 255));
         tick();
         check("b_occ_max", {31'd0, b_occ <= 5'd1}, 32'd1);
         check("b_occ_match", {27'd0, b_occ}, {31'd0, b_out_valid});
      end
      b_in_valid = 1'b0;
      b_out_ready = 1'b1;
      tick();
      tick();
      check("b_sb_drained", 32'(qb.size()), 32'd0);
      check("b_end_valid", {31'd0, b_out_valid}, 32'd0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule

// File: doc/v_v2k_pipe.md
Name: v_v2k_pipe

Overview:
Parametrised multi-stage register pipeline with valid/ready handshake. It succeeds the team's single-stage WIDTH-parameterised register test block. It carries WIDTH+1-bit data through DEPTH skid-buffered stages with per-stage stall, a synchronous flush and an occupancy counter. It sits between a producer and a consumer in the Verilog-Perl example netlists, where it exercises parameter overrides, generate loops and multi-port elaboration.

Parameters:
WIDTH, 16, data MSB index; data buses are [WIDTH:0] (WIDTH+1 bits)
DEPTH, 4, number of pipeline stages, legal range 1..16
CNT_W, 5, occupancy counter width; must satisfy 2**CNT_W > DEPTH

Ports:
clk  input  1  rising-edge clock
rst  input  1  reset, synchronous, active-high
in_valid  input  1  producer data valid
in_ready  output  1  block can accept a beat this cycle
in_data  input  WIDTH+1  producer data
out_valid  output  1  stage DEPTH-1 holds valid data
out_ready  input  1  consumer accepts a beat
out_data  output  WIDTH+1  data from stage DEPTH-1
flush  input  1  synchronous clear of all stages
occupancy  output  CNT_W  number of valid stages, 0..DEPTH

Behaviour:
- Reset (rst=1 at posedge): all stage valid bits=0; stage data=0; occupancy=0; out_valid=0; out_data=0. in_ready is combinational and therefore reads 1 during reset.
- Stage i holds v[i] and d[i]. Stage 0 is the input; stage DEPTH-1 is the output.
- Stage enable: en[DEPTH-1] = !v[DEPTH-1] | out_ready. For i<DEPTH-1: en[i] = !v[i] | en[i+1]. The ready chain is combinational across stages; there is no bubble-collapse register.
- in_ready = en[0].
- On posedge with en[i]=1: v[i] <= v[i-1] (for stage 0, v[0] <= in_valid) and d[i] <= d[i-1] (for stage 0, d[0] <= in_data).
- On posedge with en[i]=0: stage i holds its value.
- Data registers load only when the incoming valid bit is 1. Invalid beats leave data unchanged.
- Latency: DEPTH cycles from input accept to out_valid, with no stalls.
- Throughput: one beat per cycle when out_ready is held at 1.
- Accept = in_valid & in_ready. Emit = out_valid & out_ready.
- occupancy: +1 on accept only, -1 on emit only, unchanged when both or neither occur. It never exceeds DEPTH and never underflows.
- Full (occupancy==DEPTH) with out_ready=0: in_ready=0 and all data holds.
- Full with out_ready=1: accept and emit happen in the same cycle and occupancy stays at DEPTH.
- Empty: out_valid=0; out_data holds its last value.
- flush=1 at posedge: all v[i] cleared, occupancy=0, data registers untouched. An in_valid beat in the same cycle is dropped, and in_ready is forced to 0 while flush=1.
- rst has priority over flush. Asserting rst mid-stream discards all in-flight beats.
- out_valid must not deassert without an emit or flush/rst.
- out_data must be stable while out_valid=1 and out_ready=0.

Optional Feature:
V_V2K_PIPE_PARITY_EN
- Defined: adds output port parity_err (1 bit). Each stage stores the even parity of d[i], computed at load time. parity_err is registered and asserts for one cycle when stage DEPTH-1 is valid and its stored parity mismatches ^d[DEPTH-1]. Reset value 0.
- Not defined: the port is absent; there is no parity storage and no added logic.

Test Plan:
- Reset then idle, with DEPTH=4, WIDTH=16 → out_valid=0, occupancy=0, in_ready=1, out_data=17'h0.
- Stream 8 beats 0x1..0x8 with out_ready=1 → first out_valid at cycle 4 after the first accept, data in order 0x1..0x8, occupancy steady at 4.
- Fill with out_ready=0, pushing 5 beats 0xA0..0xA4 → in_ready=0 after the 4th accept, occupancy=4, 0xA4 not accepted. Then raise out_ready → 0xA0..0xA3 drain in order.
- Full with out_ready=1 and in_valid=1 for 10 cycles → occupancy stays 4, no beat lost or duplicated (scoreboard).
- Three beats in flight, then flush=1 for one cycle with in_valid=1 → occupancy=0, out_valid=0 next cycle, flushed beats never appear on out_data.
- Override DEPTH=1, WIDTH=7 with random valid/ready → scoreboard matches in order. With V_V2K_PIPE_PARITY_EN defined, parity_err stays 0.
